game_ctl: RTL and testbench

//  Parametrised game-flow controller: IDLE -> WAIT -> GAME -> SCORE with a

---
 rtl/game_ctl_if.sv | 50 +++++
 rtl/game_ctl.sv | 175 +++++++++++++++++
 tb/tb_game_ctl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctl_if.sv
// Signal bundle between the click/UART front end and game_ctl.
// The pause_clicked wire exists only when GAME_CTL_PAUSE_EN is defined.
interface game_ctl_if #(
   parameter int unsigned N_TARGETS = 4,
   parameter int unsigned TIMER_W   = 8,
   parameter int unsigned SCORE_W   = 10
);
   // Inputs: *_clicked and target_hit are single-cycle pulses sampled on the
   // rising pclk edge, uart_start is a level. No valid/ready back-pressure:
   // every output is a registered status, updated one cycle after its cause.
   logic                 play_clicked;
   logic                 stop_clicked;
   logic                 uart_start;
   logic [N_TARGETS-1:0] target_hit;
`ifdef GAME_CTL_PAUSE_EN
   logic                 pause_clicked;
`endif
   logic [2:0]           state;
   logic                 play_btn_vis;
   logic                 game_active;
   logic                 tick_1s;
   logic [TIMER_W-1:0]   time_left;
   logic [SCORE_W-1:0]   score;
   logic                 score_valid;
   logic                 game_over;

`ifdef GAME_CTL_PAUSE_EN
   modport master (
      output play_clicked, stop_clicked, uart_start, target_hit, pause_clicked,
      input  state, play_btn_vis, game_active, tick_1s, time_left, score,
             score_valid, game_over
   );
   modport slave (
      input  play_clicked, stop_clicked, uart_start, target_hit, pause_clicked,
      output state, play_btn_vis, game_active, tick_1s, time_left, score,
             score_valid, game_over
   );
`else
   modport master (
      output play_clicked, stop_clicked, uart_start, target_hit,
      input  state, play_btn_vis, game_active, tick_1s, time_left, score,
             score_valid, game_over
   );
   modport slave (
      input  play_clicked, stop_clicked, uart_start, target_hit,
      output state, play_btn_vis, game_active, tick_1s, time_left, score,
             score_valid, game_over
   );
`endif
endinterface

// File: rtl/game_ctl.sv
// Game-flow controller: IDLE -> WAIT -> GAME -> SCORE with seconds countdown,
// saturating multi-target score and stop abort. GAME_CTL_PAUSE_EN adds PAUSE.
module game_ctl #(
   parameter int unsigned CLK_HZ       = 40_000_000,
   parameter int unsigned GAME_SECONDS = 30,
   parameter int unsigned HOLD_SECONDS = 5,
   parameter int unsigned TIMER_W      = 8,
   parameter int unsigned N_TARGETS    = 4,
   parameter int unsigned SCORE_W      = 10
) (
   input  logic        pclk,
   input  logic        rst,
   game_ctl_if.slave   bus
);

   localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned HOLD_W  = $clog2(HOLD_SECONDS + 1);
   localparam int unsigned HIT_W   = $clog2(N_TARGETS + 1);
   localparam int unsigned SUM_W   = SCORE_W + 5;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_SECONDS - 1);
   localparam logic [TIMER_W-1:0] TIME_INIT  = TIMER_W'(GAME_SECONDS);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_GAME  = 3'd2,
      S_SCORE = 3'd3,
      S_PAUSE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [HOLD_W-1:0]  hold_q,  hold_d;
   logic [TIMER_W-1:0] time_q,  time_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               tick_q,  tick_d;
   logic               over_q,  over_d;
   logic               vis_q, active_q, valid_q;

   logic [HIT_W-1:0]   hit_cnt;
   logic [SUM_W-1:0]   score_sum;
   logic [SCORE_W-1:0] score_sat;
   logic               presc_last;

   always_comb begin
      hit_cnt = '0;
      for (int i = 0; i < int'(N_TARGETS); i++) begin
         hit_cnt = hit_cnt + HIT_W'(bus.target_hit[i]);
      end
   end

   assign score_sum  = SUM_W'(score_q) + SUM_W'(hit_cnt);
   assign score_sat  = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX
                                                       : score_sum[SCORE_W-1:0];
   assign presc_last = (presc_q == PRESC_LAST);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      hold_d  = hold_q;
      time_d  = time_q;
      score_d = score_q;
      tick_d  = 1'b0;
      over_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            presc_d = '0;
            if (bus.play_clicked) begin
               state_d = S_WAIT;
               score_d = '0;
               time_d  = TIME_INIT;
            end
         end
         S_WAIT: begin
            presc_d = '0;
            if (bus.stop_clicked) begin
               state_d = S_IDLE;
            end else if (bus.uart_start) begin
               state_d = S_GAME;
            end
         end
         S_GAME: begin
            // Stop (then pause) pre-empts everything else in this cycle,
            // so an aborted game keeps its last score and time untouched.
            if (bus.stop_clicked) begin
               state_d = S_IDLE;
            end
`ifdef GAME_CTL_PAUSE_EN
            else if (bus.pause_clicked) begin
               state_d = S_PAUSE;
            end
`endif
            else begin
               score_d = score_sat;
               if (presc_last) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
                  time_d  = time_q - TIMER_W'(1);
                  if (time_q == TIMER_W'(1)) begin
                     state_d = S_SCORE;
                     over_d  = 1'b1;
                     hold_d  = '0;
                  end
               end else begin
                  presc_d = presc_q + PRESC_W'(1);
               end
            end
         end
         S_SCORE: begin
            if (presc_last) begin
               presc_d = '0;
               tick_d  = 1'b1;
               hold_d  = hold_q + HOLD_W'(1);
            end else begin
               presc_d = presc_q + PRESC_W'(1);
            end
            if (bus.play_clicked || (presc_last && hold_q == HOLD_LAST)) begin
               state_d = S_IDLE;
            end
         end
`ifdef GAME_CTL_PAUSE_EN
         S_PAUSE: begin
            if (bus.stop_clicked) begin
               state_d = S_IDLE;
            end else if (bus.pause_clicked) begin
               state_d = S_GAME;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            presc_d = '0;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         presc_q  <= '0;
         hold_q   <= '0;
         time_q   <= TIME_INIT;
         score_q  <= '0;
         tick_q   <= 1'b0;
         over_q   <= 1'b0;
         vis_q    <= 1'b1;
         active_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         hold_q   <= hold_d;
         time_q   <= time_d;
         score_q  <= score_d;
         tick_q   <= tick_d;
         over_q   <= over_d;
         vis_q    <= (state_d == S_IDLE);
         active_q <= (state_d == S_GAME);
         valid_q  <= (state_d == S_SCORE);
      end
   end

   assign bus.state        = state_q;
   assign bus.play_btn_vis = vis_q;
   assign bus.game_active  = active_q;
   assign bus.tick_1s      = tick_q;
   assign bus.time_left    = time_q;
   assign bus.score        = score_q;
   assign bus.score_valid  = valid_q;
   assign bus.game_over    = over_q;

endmodule

// File: tb/tb_game_ctl.sv
// Bench for game_ctl: reset/flow vector table, multi-cycle corner sequences
// and a randomized run against a cycle-level game model.
module tb_game_ctl;

   localparam int CLK_HZ = 10;
   localparam int GAME_S = 3;
   localparam int HOLD_S = 2;
   localparam int NT     = 4;
   localparam int TW     = 8;
   localparam int SW     = 4;
   localparam int SMAX   = (1 << SW) - 1;

   typedef logic [19:0] out_t;

   typedef struct {
      bit         play, stop, uart;
      logic [3:0] hit;
      int         st;
      bit         vis, act, tick;
      int         tl, sc;
      bit         sv, go;
   } vec_t;

   logic pclk = 1'b0;
   logic rst  = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 pclk = ~pclk;

   game_ctl_if #(.N_TARGETS(NT), .TIMER_W(TW), .SCORE_W(SW)) bus ();

   game_ctl #(
      .CLK_HZ(CLK_HZ), .GAME_SECONDS(GAME_S), .HOLD_SECONDS(HOLD_S),
      .TIMER_W(TW), .N_TARGETS(NT), .SCORE_W(SW)
   ) dut (
      .pclk(pclk),
      .rst (rst),
      .bus (bus)
   );

   function automatic out_t pack_exp(int st, bit vis, bit act, bit tick,
                                     int tl, int sc, bit sv, bit go);
      return {3'(st), vis, act, tick, 8'(tl), 4'(sc), sv, go};
   endfunction

   function automatic out_t dut_out();
      return {bus.state, bus.play_btn_vis, bus.game_active, bus.tick_1s,
              bus.time_left, bus.score, bus.score_valid, bus.game_over};
   endfunction

   task automatic check(input string name, input out_t exp);
      out_t got;
      got = dut_out();
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got st=%0d vis=%b act=%b tick=%b tl=%0d sc=%0d sv=%b go=%b, expected st=%0d vis=%b act=%b tick=%b tl=%0d sc=%0d sv=%b go=%b",
                  name, got[19:17], got[16], got[15], got[14], got[13:6], got[5:2], got[1], got[0],
                  exp[19:17], exp[16], exp[15], exp[14], exp[13:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   task automatic check_val(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic set_in(input bit play, input bit stop, input bit uart,
                         input bit pause, input logic [3:0] hit);
      bus.play_clicked = play;
      bus.stop_clicked = stop;
      bus.uart_start   = uart;
      bus.target_hit   = hit;
`ifdef GAME_CTL_PAUSE_EN
      bus.pause_clicked = pause;
`else
      if (pause) $display("note: pause requested without pause build");
`endif
   endtask

   task automatic step();
      @(posedge pclk);
      @(negedge pclk);
   endtask

   task automatic idle_steps(input int n);
      set_in(0, 0, 0, 0, 4'h0);
      for (int i = 0; i < n; i++) step();
   endtask

   // Reference model: game phases tracked as plain integers and second counts.
   int m_mode, m_cyc, m_tl, m_score, m_held;
   bit m_tick, m_go;

   task automatic model_reset();
      m_mode = 0; m_cyc = 0; m_tl = GAME_S; m_score = 0; m_held = 0;
      m_tick = 0; m_go = 0;
   endtask

   task automatic model_step(input bit play, input bit stop, input bit uart,
                             input bit pause, input logic [3:0] hit);
      m_tick = 0;
      m_go   = 0;
      case (m_mode)
         0: if (play) begin m_mode = 1; m_score = 0; m_tl = GAME_S; end
         1: if (stop) m_mode = 0;
            else if (uart) begin m_mode = 2; m_cyc = 0; end
         2: begin
            if (stop) m_mode = 0;
            else if (pause) m_mode = 4;
            else begin
               m_score = m_score + $countones(hit);
               if (m_score > SMAX) m_score = SMAX;
               m_cyc++;
               if (m_cyc == CLK_HZ) begin
                  m_cyc = 0; m_tick = 1; m_tl--;
                  if (m_tl == 0) begin m_mode = 3; m_go = 1; m_held = 0; end
               end
            end
         end
         3: begin
            m_cyc++;
            if (m_cyc == CLK_HZ) begin m_cyc = 0; m_tick = 1; m_held++; end
            if (play || m_held == HOLD_S) m_mode = 0;
         end
         4: if (stop) m_mode = 0;
            else if (pause) m_mode = 2;
         default: m_mode = 0;
      endcase
   endtask

   function automatic out_t model_out();
      return pack_exp(m_mode, m_mode == 0, m_mode == 2, m_tick, m_tl, m_score,
                      m_mode == 3, m_go);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[19];
      logic [19:0] exp_q[$];
      int ticks, gap;
      out_t rst_vec;

      rst_vec = pack_exp(0, 1, 0, 0, GAME_S, 0, 0, 0);

      tbl[0]  = '{0, 0, 0, 4'h0, 0, 1, 0, 0, 3, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 4'hF, 0, 1, 0, 0, 3, 0, 0, 0};
      tbl[2]  = '{0, 0, 1, 4'h0, 0, 1, 0, 0, 3, 0, 0, 0};
      tbl[3]  = '{1, 0, 0, 4'h0, 1, 0, 0, 0, 3, 0, 0, 0};
      tbl[4]  = '{1, 0, 0, 4'h0, 1, 0, 0, 0, 3, 0, 0, 0};
      tbl[5]  = '{0, 1, 1, 4'h0, 0, 1, 0, 0, 3, 0, 0, 0};
      tbl[6]  = '{1, 0, 0, 4'h0, 1, 0, 0, 0, 3, 0, 0, 0};
      tbl[7]  = '{0, 0, 1, 4'h0, 2, 0, 1, 0, 3, 0, 0, 0};
      tbl[8]  = '{0, 0, 0, 4'hB, 2, 0, 1, 0, 3, 3, 0, 0};
      tbl[9]  = '{0, 0, 0, 4'hB, 2, 0, 1, 0, 3, 6, 0, 0};
      tbl[10] = '{0, 0, 0, 4'hB, 2, 0, 1, 0, 3, 9, 0, 0};
      tbl[11] = '{0, 0, 0, 4'hB, 2, 0, 1, 0, 3, 12, 0, 0};
      tbl[12] = '{0, 0, 0, 4'hB, 2, 0, 1, 0, 3, 15, 0, 0};
      tbl[13] = '{0, 0, 0, 4'hB, 2, 0, 1, 0, 3, 15, 0, 0};
      tbl[14] = '{0, 0, 0, 4'h0, 2, 0, 1, 0, 3, 15, 0, 0};
      tbl[15] = '{0, 0, 0, 4'h0, 2, 0, 1, 0, 3, 15, 0, 0};
      tbl[16] = '{0, 0, 0, 4'h0, 2, 0, 1, 0, 3, 15, 0, 0};
      tbl[17] = '{0, 0, 0, 4'h0, 2, 0, 1, 1, 2, 15, 0, 0};
      tbl[18] = '{0, 1, 0, 4'hF, 0, 1, 0, 0, 2, 15, 0, 0};

      // Clock/reset: hold reset for 3 cycles, release on a falling edge.
      set_in(0, 0, 0, 0, 4'h0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge pclk);
      check("reset_held", rst_vec);
      rst = 1'b1;
      #1;
      check("reset_release", rst_vec);

      for (int i = 0; i < 19; i++) begin
         set_in(tbl[i].play, tbl[i].stop, tbl[i].uart, 0, tbl[i].hit);
         step();
         check($sformatf("tbl%0d", i),
               pack_exp(tbl[i].st, tbl[i].vis, tbl[i].act, tbl[i].tick,
                        tbl[i].tl, tbl[i].sc, tbl[i].sv, tbl[i].go));
      end

      // Full game then SCORE hold back to IDLE.
      set_in(1, 0, 0, 0, 4'h0); step();
      set_in(0, 0, 1, 0, 4'h0); step();
      check("a_enter_game", pack_exp(2, 0, 1, 0, 3, 0, 0, 0));
      ticks = 0;
      set_in(0, 0, 0, 0, 4'h0);
      for (int c = 1; c <= 30; c++) begin
         step();
         if (bus.tick_1s === 1'b1) ticks++;
      end
      check_val("a_ticks", ticks, 3);
      check("a_game_end", pack_exp(3, 0, 0, 1, 0, 0, 1, 1));
      step();
      check("a_over_pulse", pack_exp(3, 0, 0, 0, 0, 0, 1, 0));
      idle_steps(18);
      check("a_score_hold", pack_exp(3, 0, 0, 0, 0, 0, 1, 0));
      step();
      check("a_back_idle", pack_exp(0, 1, 0, 1, 0, 0, 0, 0));

      // Stop in the same cycle as the final tick.
      set_in(1, 0, 0, 0, 4'h0); step();
      set_in(0, 0, 1, 0, 4'h0); step();
      idle_steps(29);
      check("b_before_final", pack_exp(2, 0, 1, 0, 1, 0, 0, 0));
      set_in(0, 1, 0, 0, 4'h0); step();
      check("b_stop_final", pack_exp(0, 1, 0, 0, 1, 0, 0, 0));
      idle_steps(1);
      check("b_no_over", pack_exp(0, 1, 0, 0, 1, 0, 0, 0));

      // Asynchronous reset mid-game.
      set_in(1, 0, 0, 0, 4'h4); step();
      set_in(0, 0, 1, 0, 4'h1); step();
      idle_steps(12);
      check("c_mid_game", pack_exp(2, 0, 1, 0, 2, 0, 0, 0));
      #2 rst = 1'b0;
      #1;
      check("c_async_rst", rst_vec);
      @(negedge pclk);
      rst = 1'b1;
      step();
      check("c_after_rst", rst_vec);

`ifdef GAME_CTL_PAUSE_EN
      // Pause at time_left=2 with three cycles of the second already spent.
      set_in(1, 0, 0, 0, 4'h0); step();
      set_in(0, 0, 1, 0, 4'h0); step();
      idle_steps(13);
      set_in(0, 0, 0, 1, 4'h0); step();
      check("d_paused", pack_exp(4, 0, 0, 0, 2, 0, 0, 0));
      ticks = 0;
      set_in(0, 0, 0, 0, 4'hF);
      for (int c = 0; c < 50; c++) begin
         step();
         if (bus.tick_1s === 1'b1) ticks++;
      end
      check_val("d_pause_ticks", ticks, 0);
      check("d_pause_hold", pack_exp(4, 0, 0, 0, 2, 0, 0, 0));
      set_in(0, 0, 0, 1, 4'h0); step();
      check("d_resume", pack_exp(2, 0, 1, 0, 2, 0, 0, 0));
      set_in(0, 0, 0, 0, 4'h0);
      gap = -1;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (bus.tick_1s === 1'b1) begin gap = c; break; end
      end
      check_val("d_resume_gap", gap, 7);
      set_in(0, 1, 0, 1, 4'h0); step();
      check("d_stop", pack_exp(0, 1, 0, 0, 1, 0, 0, 0));
`endif

      // Randomized run against the model.
      set_in(0, 0, 0, 0, 4'h0);
      @(negedge pclk);
      rst = 1'b0;
      @(negedge pclk);
      rst = 1'b1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         bit p, s, u, pz;
         logic [3:0] h;
         p  = ($urandom_range(0, 7) == 0);
         s  = ($urandom_range(0, 59) == 0);
         u  = ($urandom_range(0, 3) == 0);
`ifdef GAME_CTL_PAUSE_EN
         pz = ($urandom_range(0, 24) == 0);
`else
         pz = 1'b0;
`endif
         for (int b = 0; b < 4; b++) h[b] = ($urandom_range(0, 3) == 0);
         set_in(p, s, u, pz, h);
         model_step(p, s, u, pz, h);
         exp_q.push_back(model_out());
         step();
         check($sformatf("rand%0d", c), exp_q.pop_front());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
